thermal_sensor_scanner: RTL and testbench

Sensor-side producer for the thermal throttle's sensor interface. It sequences a shared, muxed thermal-sensor ADC round-robin across enabled sensors and applies a per-sensor signed calibration offset. It drives the 12-bit code, valid strobe and analog-ready flag that the throttle logic consumes, and detects ADC conversion timeouts.

---
 rtl/thermal_sensor_scanner.sv | 186 ++++++++++++++++++
 tb/tb_thermal_sensor_scanner.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/thermal_sensor_scanner.sv
// Round-robin sequencer for a shared thermal-sensor ADC with per-sensor calibration and timeout detection.
// Latency: done sampled at T -> calibrated code and valid strobe at T+2. No backpressure: the ADC paces the scan.
`timescale 1ns/1ps

module thermal_sensor_scanner #(
    parameter int NUM_SENSORS    = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int SEL_W          = $clog2(NUM_SENSORS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      scan_en_i,
    input  logic [NUM_SENSORS-1:0]    sensor_mask_i,
    input  logic [15:0]               scan_interval_i,
    input  logic [7:0]                settle_cycles_i,
    input  logic [8*NUM_SENSORS-1:0]  cal_offset_i,
    output logic [SEL_W-1:0]          adc_sel_o,
    output logic                      adc_start_o,
    input  logic                      adc_done_i,
    input  logic [11:0]               adc_data_i,
    output logic [12*NUM_SENSORS-1:0] ts_code_o,
    output logic [NUM_SENSORS-1:0]    ts_valid_o,
    output logic [NUM_SENSORS-1:0]    ts_analog_ready_o,
    output logic                      busy_o,
    output logic [15:0]               timeout_events_o
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CONVERT,
        S_CAPTURE
    } state_t;

    state_t                           r_state;
    logic [NUM_SENSORS-1:0]           r_mask;
    logic [SEL_W-1:0]                 r_sel;
    logic                             r_start;
    logic [7:0]                       r_settle_cnt;
    logic [TO_W-1:0]                  r_wait_cnt;
    logic [15:0]                      r_interval;
    logic [11:0]                      r_data;
    logic [NUM_SENSORS-1:0][11:0]     r_code;
    logic [NUM_SENSORS-1:0]           r_valid;
    logic [NUM_SENSORS-1:0]           r_ready;
    logic [15:0]                      r_timeouts;

    logic [SEL_W-1:0]                 w_first_idx;
    logic [SEL_W-1:0]                 w_next_idx;
    logic                             w_next_vld;
    logic                             w_continue;
    logic [7:0]                       w_settle_load;
    logic [NUM_SENSORS-1:0][7:0]      w_off_arr;
    logic [7:0]                       w_offset;
    logic signed [13:0]               w_sum;
    logic [11:0]                      w_code;

    // Lowest set bit of the live mask picks the first sensor of a new scan.
    always_comb begin
        w_first_idx = '0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (sensor_mask_i[i]) begin
                w_first_idx = SEL_W'(i);
            end
        end
    end

    // Next sensor is the lowest latched bit strictly above the current one.
    always_comb begin
        w_next_idx = '0;
        w_next_vld = 1'b0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (r_mask[i] && (i > int'(r_sel))) begin
                w_next_idx = SEL_W'(i);
                w_next_vld = 1'b1;
            end
        end
    end

    assign w_continue    = scan_en_i && w_next_vld;
    assign w_settle_load = (settle_cycles_i == 8'd0) ? 8'd0 : settle_cycles_i - 8'd1;

    // Offset is signed; the 14-bit sum cannot overflow for a 12-bit code plus an 8-bit offset.
    assign w_off_arr = cal_offset_i;
    assign w_offset  = w_off_arr[r_sel];
    assign w_sum     = $signed({2'b00, r_data}) + $signed({{6{w_offset[7]}}, w_offset});

    always_comb begin
        if (w_sum[13]) begin
            w_code = 12'h000;
        end else if (w_sum[12]) begin
            w_code = 12'hFFF;
        end else begin
            w_code = w_sum[11:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mask       <= '0;
            r_sel        <= '0;
            r_start      <= 1'b0;
            r_settle_cnt <= '0;
            r_wait_cnt   <= '0;
            r_interval   <= '0;
            r_data       <= '0;
            r_code       <= '0;
            r_valid      <= '0;
            r_ready      <= '0;
            r_timeouts   <= '0;
        end else begin
            r_start <= 1'b0;
            r_valid <= '0;
            case (r_state)
                S_IDLE: begin
                    if (r_interval != 16'd0) begin
                        r_interval <= r_interval - 16'd1;
                    end else if (scan_en_i && (|sensor_mask_i)) begin
                        r_mask       <= sensor_mask_i;
                        r_sel        <= w_first_idx;
                        r_settle_cnt <= w_settle_load;
                        r_state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (r_settle_cnt == 8'd0) begin
                        r_state    <= S_CONVERT;
                        r_start    <= 1'b1;
                        r_wait_cnt <= '0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt - 8'd1;
                    end
                end
                S_CONVERT: begin
                    r_wait_cnt <= r_wait_cnt + 1'b1;
                    // A done coinciding with the start pulse belongs to a previous conversion.
                    if (!r_start && adc_done_i) begin
                        r_data  <= adc_data_i;
                        r_state <= S_CAPTURE;
                    end else if (r_wait_cnt == TO_W'(TIMEOUT_CYCLES)) begin
                        r_ready[r_sel] <= 1'b0;
                        if (r_timeouts != 16'hFFFF) begin
                            r_timeouts <= r_timeouts + 16'd1;
                        end
                        if (w_continue) begin
                            r_sel        <= w_next_idx;
                            r_settle_cnt <= w_settle_load;
                            r_state      <= S_SETTLE;
                        end else begin
                            r_interval <= scan_interval_i;
                            r_state    <= S_IDLE;
                        end
                    end
                end
                S_CAPTURE: begin
                    r_code[r_sel]  <= w_code;
                    r_valid[r_sel] <= 1'b1;
                    r_ready[r_sel] <= 1'b1;
                    if (w_continue) begin
                        r_sel        <= w_next_idx;
                        r_settle_cnt <= w_settle_load;
                        r_state      <= S_SETTLE;
                    end else begin
                        r_interval <= scan_interval_i;
                        r_state    <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign adc_sel_o         = r_sel;
    assign adc_start_o       = r_start;
    assign ts_code_o         = r_code;
    assign ts_valid_o        = r_valid;
    assign ts_analog_ready_o = r_ready;
    assign busy_o            = (r_state != S_IDLE);
    assign timeout_events_o  = r_timeouts;

endmodule

// File: tb/tb_thermal_sensor_scanner.sv
// Bench for thermal_sensor_scanner: behavioural ADC responder, per-sensor result model and scenario tasks.
`timescale 1ns/1ps

module tb_thermal_sensor_scanner;

    localparam int NS = 8;
    localparam int TO = 16;
    localparam int SW = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              scan_en_i = 1'b0;
    logic [NS-1:0]     sensor_mask_i = '0;
    logic [15:0]       scan_interval_i = '0;
    logic [7:0]        settle_cycles_i = 8'd2;
    logic [8*NS-1:0]   cal_offset_i = '0;
    logic [SW-1:0]     adc_sel_o;
    logic              adc_start_o;
    logic              adc_done_i;
    logic [11:0]       adc_data_i;
    logic [12*NS-1:0]  ts_code_o;
    logic [NS-1:0]     ts_valid_o;
    logic [NS-1:0]     ts_analog_ready_o;
    logic              busy_o;
    logic [15:0]       timeout_events_o;

    thermal_sensor_scanner #(.NUM_SENSORS(NS), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .scan_en_i(scan_en_i), .sensor_mask_i(sensor_mask_i),
        .scan_interval_i(scan_interval_i), .settle_cycles_i(settle_cycles_i),
        .cal_offset_i(cal_offset_i), .adc_sel_o(adc_sel_o), .adc_start_o(adc_start_o),
        .adc_done_i(adc_done_i), .adc_data_i(adc_data_i), .ts_code_o(ts_code_o),
        .ts_valid_o(ts_valid_o), .ts_analog_ready_o(ts_analog_ready_o), .busy_o(busy_o),
        .timeout_events_o(timeout_events_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [11:0] rsp_data [NS];
    bit          rsp_mute [NS];
    int          rsp_delay = 3;
    logic        rsp_done = 1'b0;
    logic [11:0] rsp_q = '0;
    logic        stray_done = 1'b0;

    assign adc_done_i = rsp_done | stray_done;
    assign adc_data_i = stray_done ? 12'hABC : rsp_q;

    int st_sel[$], st_cyc[$], v_idx[$], v_code[$], v_cyc[$], d_cyc[$];
    int e_idx[$], e_code[$];
    int multi_hot = 0;
    int exp_code [NS];
    logic [NS-1:0] exp_ready = '0;
    int exp_to = 0;

    initial forever @(posedge clk) cyc++;

    // Behavioural ADC: answers rsp_delay cycles after each start pulse unless the sensor is muted.
    initial begin
        int cnt;
        int psel;
        bit pend;
        pend = 0; cnt = 0; psel = 0;
        forever begin
            @(negedge clk);
            rsp_done = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 0;
                    if (!rsp_mute[psel]) begin
                        rsp_done = 1'b1;
                        rsp_q = rsp_data[psel];
                        d_cyc.push_back(cyc);
                    end
                end
            end
            if (adc_start_o) begin
                pend = 1; cnt = rsp_delay; psel = int'(adc_sel_o);
            end
            if (!rst_n) pend = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (adc_start_o) begin
            st_sel.push_back(int'(adc_sel_o));
            st_cyc.push_back(cyc);
        end
        if (ts_valid_o != '0) begin
            if ($countones(ts_valid_o) > 1) multi_hot++;
            for (int i = 0; i < NS; i++) begin
                if (ts_valid_o[i]) begin
                    v_idx.push_back(i);
                    v_code.push_back(int'(ts_code_o[i*12 +: 12]));
                    v_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    function automatic int clamp_code(logic [11:0] d, logic [7:0] o);
        int s;
        s = int'(d) + (o[7] ? int'(o) - 256 : int'(o));
        if (s < 0) return 0;
        if (s > 4095) return 4095;
        return s;
    endfunction

    function automatic logic [12*NS-1:0] exp_codes();
        logic [12*NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i*12 +: 12] = 12'(exp_code[i]);
        return v;
    endfunction

    // Predicts one scan: ascending over the mask, at most 'limit' sensors (limit<0 means all).
    task automatic model_scan(input logic [NS-1:0] m, input int limit);
        int n;
        n = 0;
        for (int i = 0; i < NS; i++) begin
            if (m[i] && (limit < 0 || n < limit)) begin
                n++;
                if (rsp_mute[i]) begin
                    exp_ready[i] = 1'b0;
                    if (exp_to < 65535) exp_to++;
                end else begin
                    exp_code[i] = clamp_code(rsp_data[i], cal_offset_i[i*8 +: 8]);
                    exp_ready[i] = 1'b1;
                    e_idx.push_back(i);
                    e_code.push_back(exp_code[i]);
                end
            end
        end
    endtask

    task automatic clear_logs();
        st_sel.delete(); st_cyc.delete(); v_idx.delete(); v_code.delete();
        v_cyc.delete(); d_cyc.delete(); e_idx.delete(); e_code.delete();
    endtask

    task automatic run_scan(input logic [NS-1:0] m, output bit ok);
        sensor_mask_i = m;
        scan_en_i = 1'b1;
        ok = 0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (busy_o) begin ok = 1; break; end
        end
        if (ok) begin
            ok = 0;
            for (int k = 0; k < 4000; k++) begin
                @(negedge clk);
                if (!busy_o) begin ok = 1; break; end
            end
        end
        scan_en_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
        checks++; if (adc_start_o !== 1'b0 || adc_sel_o !== '0) begin errors++; $display("FAIL reset_adc got start=%b sel=%0d exp 0/0", adc_start_o, adc_sel_o); end
        checks++; if (ts_code_o !== '0 || ts_valid_o !== '0) begin errors++; $display("FAIL reset_ts got code=%h valid=%h exp 0", ts_code_o, ts_valid_o); end
        checks++; if (ts_analog_ready_o !== '0 || timeout_events_o !== '0) begin errors++; $display("FAIL reset_rdy got rdy=%h to=%0d exp 0", ts_analog_ready_o, timeout_events_o); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit ok;
        for (int i = 0; i < NS; i++) begin rsp_data[i] = 12'h300; rsp_mute[i] = 0; exp_code[i] = 0; end
        cal_offset_i = '0; settle_cycles_i = 8'd2; rsp_delay = 3; scan_interval_i = 16'd0;
        clear_logs();
        model_scan(8'b0000_0101, -1);
        run_scan(8'b0000_0101, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done got=timeout exp=scan completes"); end
        checks++; if (st_sel.size() != 2) begin errors++; $display("FAIL basic_starts got=%0d exp=2", st_sel.size()); end
        else begin
            checks++; if (st_sel[0] != 0 || st_sel[1] != 2) begin errors++; $display("FAIL basic_sel got=%0d,%0d exp=0,2", st_sel[0], st_sel[1]); end
        end
        checks++; if (v_idx.size() != 2) begin errors++; $display("FAIL basic_valids got=%0d exp=2", v_idx.size()); end
        for (int k = 0; k < v_idx.size() && k < e_idx.size(); k++) begin
            checks++; if (v_idx[k] != e_idx[k] || v_code[k] != e_code[k]) begin errors++; $display("FAIL basic_pulse%0d got=%0d:%h exp=%0d:%h", k, v_idx[k], v_code[k], e_idx[k], e_code[k]); end
        end
        if (v_cyc.size() > 0 && d_cyc.size() > 0) begin
            checks++; if (v_cyc[0] - d_cyc[0] != 2) begin errors++; $display("FAIL basic_latency got=%0d exp=2", v_cyc[0] - d_cyc[0]); end
        end
        checks++; if (ts_analog_ready_o !== 8'b0000_0101) begin errors++; $display("FAIL basic_ready got=%b exp=00000101", ts_analog_ready_o); end
        checks++; if (ts_code_o[0 +: 12] !== 12'h300 || ts_code_o[24 +: 12] !== 12'h300) begin errors++; $display("FAIL basic_code got=%h,%h exp=300,300", ts_code_o[0 +: 12], ts_code_o[24 +: 12]); end
    endtask

    task automatic test_cal_sat();
        bit ok;
        logic [11:0] d_t [3];
        logic [7:0]  o_t [3];
        logic [11:0] c_t [3];
        d_t = '{12'hFFE, 12'h003, 12'h100};
        o_t = '{8'h05, 8'hF8, 8'hFF};
        c_t = '{12'hFFF, 12'h000, 12'h0FF};
        for (int t = 0; t < 3; t++) begin
            rsp_data[1] = d_t[t];
            cal_offset_i[8 +: 8] = o_t[t];
            clear_logs();
            model_scan(8'b0000_0010, -1);
            run_scan(8'b0000_0010, ok);
            checks++; if (ts_code_o[12 +: 12] !== c_t[t]) begin errors++; $display("FAIL cal_sat%0d got=%h exp=%h", t, ts_code_o[12 +: 12], c_t[t]); end
            checks++; if (v_code.size() != 1 || v_code[0] != int'(c_t[t])) begin errors++; $display("FAIL cal_pulse%0d got=%0d pulses exp=1 with %h", t, v_code.size(), c_t[t]); end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        settle_cycles_i = 8'd2; rsp_delay = 3;
        rsp_data[3] = 12'h456; rsp_data[4] = 12'h567;
        clear_logs(); model_scan(8'h18, -1); run_scan(8'h18, ok);
        checks++; if (ts_analog_ready_o[3] !== 1'b1) begin errors++; $display("FAIL to_pre_ready got=%b exp=1", ts_analog_ready_o[3]); end
        rsp_mute[3] = 1;
        clear_logs(); model_scan(8'h18, -1); run_scan(8'h18, ok);
        checks++; if (!ok) begin errors++; $display("FAIL to_done got=timeout exp=scan completes"); end
        checks++; if (ts_analog_ready_o[3] !== 1'b0) begin errors++; $display("FAIL to_ready got=%b exp=0", ts_analog_ready_o[3]); end
        checks++; if (int'(timeout_events_o) != exp_to) begin errors++; $display("FAIL to_count got=%0d exp=%0d", timeout_events_o, exp_to); end
        checks++; if (v_idx.size() != 1 || v_idx[0] != 4) begin errors++; $display("FAIL to_valids got=%0d pulses exp=1 on sensor 4", v_idx.size()); end
        if (st_cyc.size() == 2) begin
            checks++; if (st_cyc[1] - st_cyc[0] != TO + 3) begin errors++; $display("FAIL to_spacing got=%0d exp=%0d", st_cyc[1] - st_cyc[0], TO + 3); end
        end
        rsp_mute[3] = 0;
        clear_logs(); model_scan(8'h08, -1); run_scan(8'h08, ok);
        checks++; if (ts_analog_ready_o !== exp_ready) begin errors++; $display("FAIL to_restore got=%b exp=%b", ts_analog_ready_o, exp_ready); end
        checks++; if (ts_code_o !== exp_codes()) begin errors++; $display("FAIL to_codes got=%h exp=%h", ts_code_o, exp_codes()); end
    endtask

    task automatic test_interval();
        int c0, c1, c2, idle;
        bit ok;
        settle_cycles_i = 8'd2; rsp_delay = 3; rsp_data[0] = 12'h7A1;
        scan_interval_i = 16'd100; sensor_mask_i = 8'h01; scan_en_i = 1'b1;
        c0 = -1; c1 = -1; c2 = -1; idle = 0;
        for (int k = 0; k < 300 && c0 < 0; k++) begin @(negedge clk); if (adc_start_o) c0 = cyc; end
        for (int k = 0; k < 400 && c1 < 0; k++) begin @(negedge clk); if (adc_start_o) c1 = cyc; end
        scan_interval_i = 16'd0;
        for (int k = 0; k < 100 && c2 < 0; k++) begin
            @(negedge clk);
            if (adc_start_o) c2 = cyc;
            else if (!busy_o) idle++;
        end
        scan_en_i = 1'b0;
        ok = 0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (!busy_o) begin ok = 1; break; end end
        repeat (2) @(negedge clk);
        clear_logs();
        for (int s = 0; s < 3; s++) model_scan(8'h01, -1);
        checks++; if (c0 < 0 || c1 < 0 || c1 - c0 != 100 + 2 + 3 + 3) begin errors++; $display("FAIL interval_100 got=%0d exp=%0d", c1 - c0, 108); end
        checks++; if (c2 < 0 || c2 - c1 != 0 + 2 + 3 + 3) begin errors++; $display("FAIL interval_0 got=%0d exp=8", c2 - c1); end
        checks++; if (idle != 1) begin errors++; $display("FAIL interval_idle got=%0d exp=1", idle); end
        checks++; if (!ok || ts_code_o !== exp_codes()) begin errors++; $display("FAIL interval_code got=%h exp=%h", ts_code_o, exp_codes()); end
    endtask

    task automatic test_disable();
        bit ok;
        int seq [8];
        for (int i = 0; i < NS; i++) rsp_data[i] = 12'($urandom);
        settle_cycles_i = 8'd0; rsp_delay = 4; scan_interval_i = 16'd0;
        clear_logs(); model_scan(8'hFF, 2);
        sensor_mask_i = 8'hFF; scan_en_i = 1'b1; ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (adc_start_o && adc_sel_o == 3'd1) begin ok = 1; break; end
        end
        scan_en_i = 1'b0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (!busy_o) break; end
        repeat (2) @(negedge clk);
        checks++; if (!ok || busy_o !== 1'b0) begin errors++; $display("FAIL dis_busy got=%b exp=0", busy_o); end
        checks++; if (st_sel.size() != 2 || v_idx.size() != 2) begin errors++; $display("FAIL dis_count got=%0d starts %0d pulses exp=2/2", st_sel.size(), v_idx.size()); end
        for (int k = 0; k < v_idx.size() && k < e_idx.size(); k++) begin
            checks++; if (v_idx[k] != e_idx[k] || v_code[k] != e_code[k]) begin errors++; $display("FAIL dis_pulse%0d got=%0d:%h exp=%0d:%h", k, v_idx[k], v_code[k], e_idx[k], e_code[k]); end
        end
        if (st_cyc.size() >= 2) begin
            checks++; if (st_cyc[1] - st_cyc[0] != rsp_delay + 3) begin errors++; $display("FAIL dis_settle0 got=%0d exp=%0d", st_cyc[1] - st_cyc[0], rsp_delay + 3); end
        end
        checks++; if (ts_code_o !== exp_codes() || ts_analog_ready_o !== exp_ready) begin errors++; $display("FAIL dis_state got=%h/%b exp=%h/%b", ts_code_o, ts_analog_ready_o, exp_codes(), exp_ready); end

        seq = '{0, 7, 1, 2, 3, 4, 5, 6};
        clear_logs(); model_scan(8'h81, -1); model_scan(8'h7E, -1);
        sensor_mask_i = 8'h81; scan_en_i = 1'b1;
        for (int k = 0; k < 400; k++) begin @(negedge clk); if (busy_o) break; end
        sensor_mask_i = 8'h7E;
        for (int k = 0; k < 2000; k++) begin @(negedge clk); if (st_sel.size() >= 8) break; end
        scan_en_i = 1'b0;
        for (int k = 0; k < 100; k++) begin @(negedge clk); if (!busy_o) break; end
        repeat (2) @(negedge clk);
        checks++; if (st_sel.size() != 8) begin errors++; $display("FAIL mask_starts got=%0d exp=8", st_sel.size()); end
        for (int k = 0; k < 8 && k < st_sel.size(); k++) begin
            checks++; if (st_sel[k] != seq[k]) begin errors++; $display("FAIL mask_sel%0d got=%0d exp=%0d", k, st_sel[k], seq[k]); end
        end
        checks++; if (ts_code_o !== exp_codes()) begin errors++; $display("FAIL mask_codes got=%h exp=%h", ts_code_o, exp_codes()); end
    endtask

    task automatic test_random();
        bit ok;
        for (int it = 0; it < 15; it++) begin
            logic [NS-1:0] m;
            m = NS'($urandom_range(1, 255));
            settle_cycles_i = 8'($urandom_range(0, 4));
            rsp_delay = $urandom_range(1, 12);
            for (int i = 0; i < NS; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    if ($urandom_range(0, 1) == 1) rsp_data[i] = 12'hFF8 + 12'($urandom_range(0, 7));
                    else rsp_data[i] = 12'($urandom_range(0, 7));
                end else begin
                    rsp_data[i] = 12'($urandom);
                end
                cal_offset_i[i*8 +: 8] = 8'($urandom_range(0, 255));
                rsp_mute[i] = ($urandom_range(0, 7) == 0);
            end
            clear_logs(); model_scan(m, -1); run_scan(m, ok);
            checks++; if (!ok || v_idx.size() != e_idx.size()) begin errors++; $display("FAIL rnd%0d_pulses got=%0d exp=%0d", it, v_idx.size(), e_idx.size()); end
            for (int k = 0; k < v_idx.size() && k < e_idx.size(); k++) begin
                checks++; if (v_idx[k] != e_idx[k] || v_code[k] != e_code[k]) begin errors++; $display("FAIL rnd%0d_pulse%0d got=%0d:%h exp=%0d:%h", it, k, v_idx[k], v_code[k], e_idx[k], e_code[k]); end
            end
            checks++; if (ts_code_o !== exp_codes()) begin errors++; $display("FAIL rnd%0d_codes got=%h exp=%h", it, ts_code_o, exp_codes()); end
            checks++; if (ts_analog_ready_o !== exp_ready || int'(timeout_events_o) != exp_to) begin errors++; $display("FAIL rnd%0d_rdy got=%b/%0d exp=%b/%0d", it, ts_analog_ready_o, timeout_events_o, exp_ready, exp_to); end
        end
        for (int i = 0; i < NS; i++) rsp_mute[i] = 0;
        checks++; if (multi_hot != 0) begin errors++; $display("FAIL valid_onehot got=%0d multi-bit cycles exp=0", multi_hot); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        settle_cycles_i = 8'd2; rsp_mute[0] = 1; sensor_mask_i = 8'h01; scan_en_i = 1'b1;
        ok = 0;
        for (int k = 0; k < 400; k++) begin @(negedge clk); if (adc_start_o) begin ok = 1; break; end end
        repeat (3) @(negedge clk);
        rst_n = 1'b0; scan_en_i = 1'b0;
        @(negedge clk);
        checks++; if (!ok || busy_o !== 1'b0 || ts_valid_o !== '0) begin errors++; $display("FAIL rstmid_busy got=%b/%h exp=0/0", busy_o, ts_valid_o); end
        checks++; if (ts_code_o !== '0 || ts_analog_ready_o !== '0 || timeout_events_o !== '0) begin errors++; $display("FAIL rstmid_out got=%h/%b/%0d exp=0", ts_code_o, ts_analog_ready_o, timeout_events_o); end
        rst_n = 1'b1;
        for (int i = 0; i < NS; i++) exp_code[i] = 0;
        exp_ready = '0; exp_to = 0;
        clear_logs();
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (v_idx.size() != 0 || busy_o !== 1'b0 || ts_code_o !== '0) begin errors++; $display("FAIL rstmid_stray got=%0d pulses busy=%b exp=0/0", v_idx.size(), busy_o); end
        rsp_mute[0] = 0;
        clear_logs(); model_scan(8'h06, -1); run_scan(8'h06, ok);
        checks++; if (st_sel.size() == 0 || st_sel[0] != 1) begin errors++; $display("FAIL rstmid_first got=%0d starts exp=first sel 1", st_sel.size()); end
        checks++; if (ts_code_o !== exp_codes() || ts_analog_ready_o !== exp_ready) begin errors++; $display("FAIL rstmid_rescan got=%h/%b exp=%h/%b", ts_code_o, ts_analog_ready_o, exp_codes(), exp_ready); end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin rsp_data[i] = '0; rsp_mute[i] = 0; exp_code[i] = 0; end
        test_reset();
        test_basic();
        test_cal_sat();
        test_timeout();
        test_interval();
        test_disable();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
